// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: N_REGS shadow registers feeding user-side active registers,
// either committed together through a control register or written straight through.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR    = 32'h01180200,
    parameter logic [31:0] C_HIGHADDR    = 32'h011802FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          N_REGS        = 4,
    parameter int          C_AUTO_COMMIT = 0
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [N_REGS*32-1:0]      user_data_out,
    output logic                      user_update,
    output logic [N_REGS-1:0]         user_reg_wr
);

    localparam logic [C_OPB_AWIDTH-1:0] LP_BASE = C_OPB_AWIDTH'(C_BASEADDR);
    localparam logic [C_OPB_AWIDTH-1:0] LP_HIGH = C_OPB_AWIDTH'(C_HIGHADDR);
    localparam logic [C_OPB_AWIDTH-1:0] LP_CTRL = C_OPB_AWIDTH'(N_REGS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_HOLD
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [31:0]               r_shadow [N_REGS];
    logic [31:0]               r_active [N_REGS];
    logic                      r_dirty;
    logic                      r_update;
    logic [N_REGS-1:0]         r_reg_wr;

    logic [C_OPB_AWIDTH-1:0]   w_addr;
    logic [C_OPB_AWIDTH-1:0]   w_offset;
    logic [C_OPB_AWIDTH-1:0]   w_word;
    logic [31:0]               w_wdata;
    logic                      w_in_win;
    logic                      w_hit;
    logic                      w_is_reg;
    logic                      w_is_ctrl;
    logic [31:0]               w_sel_shadow;
    logic [31:0]               w_merged;
    logic [31:0]               w_rdata;
    logic                      w_ack;
    logic                      w_wr;
    logic                      w_commit;
    logic                      w_unused;

    assign w_unused  = OPB_seqAddr;
    assign w_addr    = OPB_ABus;
    assign w_wdata   = OPB_DBus;
    assign w_in_win  = (w_addr >= LP_BASE) && (w_addr <= LP_HIGH);
    assign w_hit     = OPB_select && w_in_win;
    assign w_offset  = w_addr - LP_BASE;
    assign w_word    = w_offset >> 2;
    assign w_is_ctrl = (w_word == LP_CTRL);

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A select held high after the ack parks in HOLD so one transfer never acks twice.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_hit) w_next = S_ACK;
            S_ACK:   w_next = S_HOLD;
            S_HOLD:  if (!OPB_select) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel_shadow = '0;
        w_is_reg     = 1'b0;
        for (int k = 0; k < N_REGS; k++) begin
            if (w_word == C_OPB_AWIDTH'(k)) begin
                w_sel_shadow = r_shadow[k];
                w_is_reg     = 1'b1;
            end
        end
    end

    // Lane i of the big-endian bus lands in register byte 3-i.
    always_comb begin
        w_merged = w_sel_shadow;
        for (int j = 0; j < 4; j++) begin
            if (OPB_BE[3-j]) w_merged[8*j +: 8] = w_wdata[8*j +: 8];
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_is_reg)       w_rdata = w_sel_shadow;
        else if (w_is_ctrl) w_rdata = {31'b0, r_dirty};
    end

    assign w_ack    = (r_state == S_ACK) && !OPB_Rst;
    assign w_wr     = w_ack && !OPB_RNW && OPB_select && w_in_win;
    assign w_commit = w_wr && w_is_ctrl && OPB_BE[3] && w_wdata[0] && (C_AUTO_COMMIT == 0);

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int k = 0; k < N_REGS; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
            r_dirty  <= 1'b0;
            r_update <= 1'b0;
            r_reg_wr <= '0;
        end else begin
            r_update <= 1'b0;
            r_reg_wr <= '0;
            if (w_wr && w_is_reg) begin
                for (int k = 0; k < N_REGS; k++) begin
                    if (w_word == C_OPB_AWIDTH'(k)) begin
                        r_shadow[k] <= w_merged;
                        if (C_AUTO_COMMIT != 0) begin
                            r_active[k] <= w_merged;
                            r_reg_wr[k] <= 1'b1;
                            r_update    <= 1'b1;
                        end else begin
                            r_dirty     <= 1'b1;
                        end
                    end
                end
            end
            // Commit flags only the registers whose visible value is about to change.
            if (w_commit) begin
                for (int k = 0; k < N_REGS; k++) begin
                    r_active[k] <= r_shadow[k];
                    r_reg_wr[k] <= (r_shadow[k] != r_active[k]);
                end
                r_update <= 1'b1;
                r_dirty  <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_REGS; g++) begin : g_out
        assign user_data_out[32*g +: 32] = r_active[g];
    end

    assign Sl_DBus     = (w_ack && OPB_RNW) ? w_rdata : '0;
    assign Sl_xferAck  = w_ack;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_update = r_update;
    assign user_reg_wr = r_reg_wr;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Drives a commit-mode and a write-through instance with the same OPB traffic and
// compares both against a behavioural register-bank model.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h01180200;
    localparam logic [31:0] HIGH = 32'h011802FF;
    localparam int          NR   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] abus = '0;
    logic [31:0] dbusIn = '0;
    logic [3:0]  be = '0;
    logic        rnw = 1'b0;
    logic        sel = 1'b0;
    logic        seqAddr = 1'b0;

    logic [31:0]      dbus0, dbus1;
    logic             ack0, ack1, err0, err1, retry0, retry1, tout0, tout1;
    logic [NR*32-1:0] data0, data1;
    logic             upd0, upd1;
    logic [NR-1:0]    regWr0, regWr1;

    logic [31:0]      obsDbus [2];
    logic             obsAck [2];
    logic [NR*32-1:0] obsData [2];
    logic             obsUpd [2];
    logic [NR-1:0]    obsRegWr [2];
    logic             obsTied [2];

    assign obsDbus[0]  = dbus0;
    assign obsDbus[1]  = dbus1;
    assign obsAck[0]   = ack0;
    assign obsAck[1]   = ack1;
    assign obsData[0]  = data0;
    assign obsData[1]  = data1;
    assign obsUpd[0]   = upd0;
    assign obsUpd[1]   = upd1;
    assign obsRegWr[0] = regWr0;
    assign obsRegWr[1] = regWr1;
    assign obsTied[0]  = err0 | retry0 | tout0;
    assign obsTied[1]  = err1 | retry1 | tout1;

    int checks = 0;
    int failures = 0;

    logic [31:0] mShadow [2][NR];
    logic [31:0] mActive [2][NR];
    logic        mDirty [2];

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink #(.N_REGS(NR), .C_AUTO_COMMIT(0)) dut0 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbusIn),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqAddr),
        .Sl_DBus(dbus0), .Sl_xferAck(ack0), .Sl_errAck(err0), .Sl_retry(retry0),
        .Sl_toutSup(tout0), .user_data_out(data0), .user_update(upd0), .user_reg_wr(regWr0)
    );

    opb_register_bank_ppc2simulink #(.N_REGS(NR), .C_AUTO_COMMIT(1)) dut1 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbusIn),
        .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqAddr),
        .Sl_DBus(dbus1), .Sl_xferAck(ack1), .Sl_errAck(err1), .Sl_retry(retry1),
        .Sl_toutSup(tout1), .user_data_out(data1), .user_update(upd1), .user_reg_wr(regWr1)
    );

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [127:0] packActive(input int m);
        logic [127:0] v = '0;
        for (int k = 0; k < NR; k++) v = v | (128'(mActive[m][k]) << (32 * k));
        return v;
    endfunction

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < NR; k++) begin
                mShadow[m][k] = '0;
                mActive[m][k] = '0;
            end
            mDirty[m] = 1'b0;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("%s_m%0d_ack", tag, m), obsAck[m], 0);
            checkOutput($sformatf("%s_m%0d_dbus", tag, m), obsDbus[m], 0);
            checkOutput($sformatf("%s_m%0d_upd", tag, m), obsUpd[m], 0);
            checkOutput($sformatf("%s_m%0d_regwr", tag, m), obsRegWr[m], 0);
            checkOutput($sformatf("%s_m%0d_tied", tag, m), obsTied[m], 0);
            checkOutput($sformatf("%s_m%0d_data", tag, m), obsData[m], packActive(m));
        end
    endtask

    // One complete OPB transfer; bytes[j] enables register byte j (bits 8j+7:8j).
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] bytes, input logic isRead, input string tag);
        logic         inWin;
        int           w;
        logic [31:0]  expRd [2];
        logic [127:0] preData [2];
        logic         expUpd [2];
        logic [NR-1:0] expRegWr [2];
        logic [31:0]  mask;

        inWin = (addr >= BASE) && (addr <= HIGH);
        w = inWin ? int'((addr - BASE) / 4) : -1;
        mask = '0;
        for (int j = 0; j < 4; j++) if (bytes[j]) mask = mask | (32'hFF << (8 * j));
        for (int m = 0; m < 2; m++) begin
            preData[m] = packActive(m);
            expRd[m] = '0;
            if (inWin && w < NR)       expRd[m] = mShadow[m][w];
            else if (inWin && w == NR) expRd[m] = (m == 0) ? 32'(mDirty[m]) : 32'd0;
        end

        abus = addr; dbusIn = data; be = bytes; rnw = isRead; sel = 1'b1;
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("%s_m%0d_ack", tag, m), obsAck[m], inWin);
            checkOutput($sformatf("%s_m%0d_rdata", tag, m), obsDbus[m], (isRead && inWin) ? expRd[m] : 32'd0);
            checkOutput($sformatf("%s_m%0d_predata", tag, m), obsData[m], preData[m]);
        end

        if (!inWin) begin
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) checkOutput($sformatf("%s_m%0d_noack", tag, m), obsAck[m], 0);
            sel = 1'b0;
            @(posedge clk); #1;
            checkIdleOutputs({tag, "_out"});
            return;
        end

        for (int m = 0; m < 2; m++) begin
            expUpd[m] = 1'b0;
            expRegWr[m] = '0;
            if (!isRead && w < NR) begin
                mShadow[m][w] = (mShadow[m][w] & ~mask) | (data & mask);
                if (m == 1) begin
                    mActive[m][w] = mShadow[m][w];
                    expRegWr[m][w] = 1'b1;
                    expUpd[m] = 1'b1;
                end else begin
                    mDirty[m] = 1'b1;
                end
            end else if (!isRead && w == NR && m == 0 && bytes[0] && data[0]) begin
                for (int k = 0; k < NR; k++) begin
                    if (mShadow[m][k] != mActive[m][k]) expRegWr[m][k] = 1'b1;
                    mActive[m][k] = mShadow[m][k];
                end
                expUpd[m] = 1'b1;
                mDirty[m] = 1'b0;
            end
        end

        @(posedge clk); #1;
        sel = 1'b0;
        for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("%s_m%0d_ackdone", tag, m), obsAck[m], 0);
            checkOutput($sformatf("%s_m%0d_dbusidle", tag, m), obsDbus[m], 0);
            checkOutput($sformatf("%s_m%0d_data", tag, m), obsData[m], packActive(m));
            checkOutput($sformatf("%s_m%0d_upd", tag, m), obsUpd[m], expUpd[m]);
            checkOutput($sformatf("%s_m%0d_regwr", tag, m), obsRegWr[m], expRegWr[m]);
        end
        @(posedge clk); #1;
        checkIdleOutputs({tag, "_after"});
    endtask

    task automatic holdTest();
        int cnt [2];
        cnt[0] = 0; cnt[1] = 0;
        abus = BASE; rnw = 1'b1; be = 4'hF; sel = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) if (obsAck[m]) cnt[m]++;
        end
        for (int m = 0; m < 2; m++) checkOutput($sformatf("hold_m%0d_ackcount", m), 128'(cnt[m]), 1);
        sel = 1'b0;
        @(posedge clk); #1;
        checkIdleOutputs("hold_release");
    endtask

    task automatic resetMidWrite();
        abus = BASE + 32'h8; dbusIn = $urandom; be = 4'hF; rnw = 1'b0; sel = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) checkOutput($sformatf("rstmid_m%0d_ack", m), obsAck[m], 0);
        @(posedge clk); #1;
        sel = 1'b0;
        modelReset();
        checkIdleOutputs("rstmid_out");
        rst = 1'b0;
        @(posedge clk); #1;
        checkIdleOutputs("rstmid_release");
        applyStimulus(BASE + 32'h8, 32'h0, 4'hF, 1'b1, "rstmid_readback");
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  bytes;
        int          pick;

        modelReset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(BASE + 32'h04, 32'hDEADBEEF, 4'hF, 1'b0, "wr_reg1");
        applyStimulus(BASE + 32'h10, 32'h0, 4'hF, 1'b1, "rd_ctrl_dirty");
        applyStimulus(BASE + 32'h10, 32'h00000001, 4'hF, 1'b0, "commit");
        applyStimulus(BASE + 32'h10, 32'h0, 4'hF, 1'b1, "rd_ctrl_clean");
        applyStimulus(BASE + 32'h10, 32'h00000001, 4'hF, 1'b0, "commit_clean");
        applyStimulus(BASE + 32'h00, 32'h12345678, 4'b0100, 1'b0, "wr_lane1");
        applyStimulus(BASE + 32'h00, 32'h0, 4'hF, 1'b1, "rd_lane1");
        holdTest();
        applyStimulus(BASE + 32'hF0, 32'h0, 4'hF, 1'b1, "rd_unmapped");
        applyStimulus(BASE + 32'hF0, 32'hFFFFFFFF, 4'hF, 1'b0, "wr_unmapped");
        applyStimulus(32'h01180300, 32'h0, 4'hF, 1'b1, "rd_outside");
        applyStimulus(32'h01180300, 32'h11111111, 4'hF, 1'b0, "wr_outside");
        applyStimulus(BASE - 32'h4, 32'h22222222, 4'hF, 1'b0, "wr_below");
        applyStimulus(BASE + 32'h08, 32'hA5A5A5A5, 4'hF, 1'b0, "wr_reg2");
        applyStimulus(BASE + 32'h10, 32'h00000001, 4'b1110, 1'b0, "commit_nobe");
        applyStimulus(BASE + 32'h10, 32'h00000001, 4'b0001, 1'b0, "commit_be3");

        for (int i = 0; i < 80; i++) begin
            pick  = int'($urandom_range(0, 9));
            data  = $urandom;
            bytes = 4'($urandom);
            if (pick <= 5) begin
                addr = BASE + 32'(4 * $urandom_range(0, NR - 1));
            end else if (pick <= 7) begin
                addr = BASE + 32'(4 * NR);
                if ($urandom_range(0, 1) == 1) begin
                    data  = data | 32'h1;
                    bytes = bytes | 4'b0001;
                end
            end else if (pick == 8) begin
                addr = BASE + 32'(4 * $urandom_range(NR + 1, 63));
            end else begin
                addr = ($urandom_range(0, 1) == 1) ? HIGH + 32'(1 + 4 * $urandom_range(0, 15))
                                                   : BASE - 32'(4 * $urandom_range(1, 16));
            end
            applyStimulus(addr, data, bytes, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        resetMidWrite();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
